// File: rtl/cordic_fft_sequencer.sv
// rtl/cordic_fft_sequencer.sv - frame sequencer between the sample streams and the 16-point CORDIC FFT core
module cordic_fft_sequencer #(
    parameter int FFT_LATENCY = 40
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_x,
    input  logic [15:0]  in_y,
    input  logic         in_last,
    output logic [255:0] fft_xin,
    output logic [255:0] fft_yin,
    input  logic [255:0] fft_xout,
    input  logic [255:0] fft_yout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  out_x,
    output logic [15:0]  out_y,
    output logic [3:0]   out_index,
    output logic         out_last,
    output logic         busy,
    output logic         frame_err,
    output logic [7:0]   frame_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_UNLOAD} state_t;

    localparam logic [7:0] WAIT_INIT = 8'(FFT_LATENCY - 1);

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_wr_idx;
    logic [3:0]     r_rd_idx;
    logic [7:0]     r_wait_cnt;
    logic [255:0]   r_xin;
    logic [255:0]   r_yin;
    logic [255:0]   r_xres;
    logic [255:0]   r_yres;
    logic           r_frame_err;
    logic [7:0]     r_frame_count;

    logic           w_flush;
    logic           w_accept;
    logic           w_take;
    logic           w_capture;

    // Flush outranks both handshakes, so a sample or bin presented alongside it is dropped.
    assign w_flush   = flush && (r_state != S_IDLE);
    assign w_accept  = (r_state == S_LOAD) && in_valid && !w_flush;
    assign w_take    = (r_state == S_UNLOAD) && out_ready && !w_flush;
    assign w_capture = (r_state == S_WAIT) && (r_wait_cnt == 8'd0) && !w_flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_flush) begin
            w_next = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE:   w_next = S_LOAD;
                S_LOAD:   if (w_accept && r_wr_idx == 4'd15) w_next = S_WAIT;
                S_WAIT:   if (r_wait_cnt == 8'd0) w_next = S_UNLOAD;
                S_UNLOAD: if (w_take && r_rd_idx == 4'd15) w_next = S_LOAD;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_idx      <= 4'd0;
            r_rd_idx      <= 4'd0;
            r_wait_cnt    <= 8'd0;
            r_xin         <= '0;
            r_yin         <= '0;
            r_xres        <= '0;
            r_yres        <= '0;
            r_frame_err   <= 1'b0;
            r_frame_count <= 8'd0;
        end else if (w_flush) begin
            r_wr_idx <= 4'd0;
            r_rd_idx <= 4'd0;
        end else begin
            if (w_accept) begin
                r_xin[{r_wr_idx, 4'd0} +: 16] <= in_x;
                r_yin[{r_wr_idx, 4'd0} +: 16] <= in_y;
                r_wr_idx <= r_wr_idx + 4'd1;
                // Framing is by count; a misplaced in_last only raises the sticky flag.
                if (in_last != (r_wr_idx == 4'd15)) begin
                    r_frame_err <= 1'b1;
                end
                if (r_wr_idx == 4'd15) begin
                    r_wait_cnt <= WAIT_INIT;
                end
            end
            if (r_state == S_WAIT && r_wait_cnt != 8'd0) begin
                r_wait_cnt <= r_wait_cnt - 8'd1;
            end
            if (w_capture) begin
                r_xres   <= fft_xout;
                r_yres   <= fft_yout;
                r_rd_idx <= 4'd0;
            end
            if (w_take) begin
                r_rd_idx <= r_rd_idx + 4'd1;
                if (r_rd_idx == 4'd15) begin
                    r_frame_count <= r_frame_count + 8'd1;
                end
            end
        end
    end

    assign in_ready    = (r_state == S_LOAD);
    assign out_valid   = (r_state == S_UNLOAD);
    assign busy        = (r_state == S_WAIT) || (r_state == S_UNLOAD);
    assign out_index   = r_rd_idx;
    assign out_last    = (r_state == S_UNLOAD) && (r_rd_idx == 4'd15);
    assign out_x       = r_xres[{r_rd_idx, 4'd0} +: 16];
    assign out_y       = r_yres[{r_rd_idx, 4'd0} +: 16];
    assign fft_xin     = r_xin;
    assign fft_yin     = r_yin;
    assign frame_err   = r_frame_err;
    assign frame_count = r_frame_count;

endmodule

// File: doc/cordic_fft_sequencer.md
# cordic_fft_sequencer

Frame sequencer for the 16-point CORDIC FFT datapath (`main_cordic_fft`).
- Accepts a serial stream of complex 16-bit samples over a valid/ready handshake and assembles them into one 16-sample frame.
- Holds the frame stable on the FFT's parallel inputs for a fixed settling/pipeline latency, then captures the 256-bit `xout`/`yout` result buses.
- Streams the 16 result bins back out over a second valid/ready handshake.
- Sits between the processor-side stream interface and the FFT core.

## Interface
Parameters:
- `FFT_LATENCY`, default 40: cycles the FFT inputs are held stable before its outputs are captured; legal range 1–255.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous abort; returns the block to LOAD and discards the current frame.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept a sample.
- `in_x`  in  16  real part of the sample.
- `in_y`  in  16  imaginary part of the sample.
- `in_last`  in  1  producer's end-of-frame marker.
- `fft_xin`  out  256  packed real inputs to the FFT; sample k occupies [16k+15:16k], so k=0 drives `xin1` and k=15 drives `xin16`.
- `fft_yin`  out  256  packed imaginary inputs to the FFT, same packing.
- `fft_xout`  in  256  FFT real outputs; bin k occupies [16k+15:16k].
- `fft_yout`  in  256  FFT imaginary outputs, same packing.
- `out_valid`  out  1  result bin valid.
- `out_ready`  in  1  consumer accepts the bin.
- `out_x`  out  16  real part of the current bin.
- `out_y`  out  16  imaginary part of the current bin.
- `out_index`  out  4  bin number of `out_x`/`out_y`.
- `out_last`  out  1  high with bin 15.
- `busy`  out  1  high in WAIT or UNLOAD.
- `frame_err`  out  1  sticky; `in_last` was out of place.
- `frame_count`  out  8  completed frames, wraps 255→0.

## Operation
State machine: IDLE, LOAD, WAIT, UNLOAD.

- **IDLE**
  - Entered on reset.
  - Moves to LOAD unconditionally on the next clock.
- **LOAD**
  - `in_ready`=1.
  - Each accept (`in_valid`&`in_ready`) writes `in_x`/`in_y` to input buffer slot `wr_idx`, then increments `wr_idx`.
  - The accept at `wr_idx`=15 moves the block to WAIT, resets `wr_idx` to 0, and loads `wait_cnt` with `FFT_LATENCY`-1.
- **WAIT**
  - `in_ready`=0.
  - `fft_xin`/`fft_yin` stay constant; they are the input buffer, driven directly from registers.
  - `wait_cnt` decrements each cycle.
  - In the cycle where `wait_cnt`=0:
    - `fft_xout`/`fft_yout` are captured into the result buffer.
    - `rd_idx` is set to 0.
    - The block moves to UNLOAD.
- **UNLOAD**
  - `out_valid`=1.
  - `out_x`/`out_y` come from result buffer slot `rd_idx`; `out_index`=`rd_idx`; `out_last`=(`rd_idx`==15).
  - On `out_valid`&`out_ready`, `rd_idx` increments.
  - The handshake at `rd_idx`=15 moves the block to LOAD and increments `frame_count`.
  - While `out_ready`=0, all outputs hold.
- **frame_err**
  - Set on any accept where `in_last` ≠ (`wr_idx`==15).
  - Framing is by count only; `in_last` never shortens or extends a frame.
  - Cleared only by `reset`, not by `flush`.
- **flush**
  - From any state except IDLE, moves the block to LOAD next cycle and clears `wr_idx` and `rd_idx`.
  - `frame_count` is not incremented.
  - Buffer contents are left unchanged.
  - `flush` has priority over a simultaneous input or output handshake; that sample or bin is dropped.
- **Input buffer**
  - Retains the last frame until it is overwritten.
  - During LOAD, `fft_xin` changes slot by slot. The FFT output is meaningful only after WAIT.
- **Data**
  - No arithmetic on data; values pass through bit-exact, two's complement, 16 bits.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`, `out_valid`, `out_last`, `busy`, `frame_err` = 0;
  - `out_x`, `out_y`, `out_index`, `frame_count` = 0;
  - `wr_idx`, `rd_idx`, `wait_cnt` = 0;
  - input and result buffers = 0, so `fft_xin`/`fft_yin` = 0.
- First `in_ready`=1 is in the second cycle after `reset` deasserts.
- The 16th accept is at edge T:
  - WAIT covers cycles T+1 … T+`FFT_LATENCY`.
  - Capture happens at the edge ending cycle T+`FFT_LATENCY`.
  - `out_valid`=1 from cycle T+`FFT_LATENCY`+1.
- Throughput:
  - Input with `in_valid` held high: one sample per cycle.
  - Output with `out_ready` held high: one bin per cycle.
  - Frame period with both stream sides always ready: 16 + `FFT_LATENCY` + 16 cycles.
  - No overlap: LOAD is not re-entered until bin 15 is accepted.
- `in_ready`, `out_valid`, `out_last`, `out_index` and `busy` are decoded from the state register only; there is no combinational path from `in_valid` or `out_ready`.
- `reset` asserted mid-frame: every register returns to its reset value immediately (asynchronous reset); the partial frame is lost.

## Test plan
Bench uses an FFT stub: a register delay line of `FFT_LATENCY` stages, so `fft_xout`=`fft_xin` after the latency.
- Reset → `in_ready`=0 during reset; `in_ready`=1 two cycles after release; all outputs 0.
- 16 samples, x=3200 (0x0C80) and y=k, `in_last` on the 16th → `out_valid` exactly `FFT_LATENCY`+1 cycles after the 16th accept; bins 0–15 have x=3200, y=0–15; `out_last` only on index 15; `frame_count`=1; `frame_err`=0.
- Randomised `in_valid`/`out_ready` stalls (50%) over 10 frames with a ramp pattern → bit-exact ordered output, no lost or duplicated bins, `frame_count`=10.
- `in_last` asserted on sample 7 → `frame_err`=1 and stays set; 16 bins are still produced.
- `flush` raised after 9 samples, then a fresh 16-sample frame → output contains only the fresh frame; `frame_count`=1.
- `flush` raised at UNLOAD bin 5 with `out_ready` high → bin 5 not counted; next state LOAD; `frame_count` unchanged.
